// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the decode-stage hazard/flow controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DIV   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic        HOLD_ENABLE  = 1'b1;
  localparam logic        HOLD_DISABLE = 1'b0;
  localparam logic        FLUSH_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0;
  localparam logic [4:0]  ZERO_REG     = 5'h0;

  // Per-stage hold/flush bundle driven by the controller.
  typedef struct packed {
    logic hold_pc;
    logic hold_if_id;
    logic hold_id_ex;
    logic flush_if_id;
    logic flush_id_ex;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard: the load in EX writes a register that ID is about to read.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       load,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       hazard
);

  // x0 is never a real dependency, so a zero destination never stalls.
  assign hazard = load && (rd != ZERO_REG) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/flow controller around decode: redirect, load-use bubble, divider
// occupancy and external halt, plus a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_jump_flag_i,
  input  logic [31:0]      ex_jump_addr_i,
  input  logic [4:0]       id_reg1_addr_i,
  input  logic [4:0]       id_reg2_addr_i,
  input  logic             ex_load_i,
  input  logic [4:0]       ex_regw_addr_i,
  input  logic             ex_div_start_i,
  input  logic             div_ready_i,
  input  logic             bus_hold_i,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             hold_id_ex_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             jump_flag_o,
  output logic [31:0]      jump_addr_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              load_use;
  ctrl_t             ctrl;
  logic              jump_flag;
  logic [31:0]       jump_addr;

  pipe_ctrl_hazard_detect u_hazard (
    .load   (ex_load_i),
    .rd     (ex_regw_addr_i),
    .rs1    (id_reg1_addr_i),
    .rs2    (id_reg2_addr_i),
    .hazard (load_use)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    ctrl        = '0;
    jump_flag   = 1'b0;
    jump_addr   = ZERO_WORD;
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      ST_RUN: begin
        if (ex_jump_flag_i) begin
          jump_flag        = 1'b1;
          jump_addr        = ex_jump_addr_i;
          ctrl.flush_if_id = FLUSH_ENABLE;
          ctrl.flush_id_ex = FLUSH_ENABLE;
          if (FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end
        end else if (ex_div_start_i || bus_hold_i) begin
          ctrl.hold_pc    = HOLD_ENABLE;
          ctrl.hold_if_id = HOLD_ENABLE;
          ctrl.hold_id_ex = HOLD_ENABLE;
          state_d         = ex_div_start_i ? ST_DIV : ST_HALT;
        end else if (load_use) begin
          // One bubble suffices: the load has left EX by the next cycle.
          ctrl.hold_pc     = HOLD_ENABLE;
          ctrl.hold_if_id  = HOLD_ENABLE;
          ctrl.flush_id_ex = FLUSH_ENABLE;
        end
      end

      ST_DIV: begin
        if (div_ready_i) begin
          state_d = ST_RUN;
        end else begin
          ctrl.hold_pc    = HOLD_ENABLE;
          ctrl.hold_if_id = HOLD_ENABLE;
          ctrl.hold_id_ex = HOLD_ENABLE;
        end
      end

      ST_FLUSH: begin
        ctrl.flush_if_id = FLUSH_ENABLE;
        if (ex_jump_flag_i) begin
          // Latest redirect wins and restarts the flush window.
          jump_flag        = 1'b1;
          jump_addr        = ex_jump_addr_i;
          ctrl.flush_id_ex = FLUSH_ENABLE;
          flush_cnt_d      = FLUSH_LOAD;
        end else if (flush_cnt_q <= 2'd1) begin
          flush_cnt_d = 2'd0;
          state_d     = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 2'd1;
        end
      end

      ST_HALT: begin
        if (bus_hold_i) begin
          ctrl.hold_pc    = HOLD_ENABLE;
          ctrl.hold_if_id = HOLD_ENABLE;
          ctrl.hold_id_ex = HOLD_ENABLE;
        end else begin
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase

    ctrl.hold_if_id = ctrl.hold_if_id & ~ctrl.flush_if_id;
    ctrl.hold_id_ex = ctrl.hold_id_ex & ~ctrl.flush_id_ex;

    // Nothing is requested of the pipeline while reset is applied.
    if (!rst) begin
      ctrl      = '0;
      jump_flag = 1'b0;
      jump_addr = ZERO_WORD;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if (ctrl.hold_pc && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign hold_pc_o     = ctrl.hold_pc;
  assign hold_if_id_o  = ctrl.hold_if_id;
  assign hold_id_ex_o  = ctrl.hold_id_ex;
  assign flush_if_id_o = ctrl.flush_if_id;
  assign flush_id_ex_o = ctrl.flush_id_ex;
  assign jump_flag_o   = jump_flag;
  assign jump_addr_o   = jump_addr;
  assign state_o       = state_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected per-cycle outputs are queued with
// the stimulus and compared mid-cycle against a 32-bit and a 4-bit-counter instance.
module tb_pipe_ctrl;

  localparam logic [5:0] NONE = 6'b000000;  // {hold_pc,hold_if_id,hold_id_ex,flush_if_id,flush_id_ex,jump}
  localparam logic [5:0] H3   = 6'b111000;
  localparam logic [5:0] LU   = 6'b110010;
  localparam logic [5:0] JMP  = 6'b000111;
  localparam logic [5:0] FIF  = 6'b000100;
  localparam logic [1:0] RUN = 2'd0, DIV = 2'd1, FLS = 2'd2, HLT = 2'd3;

  typedef struct packed {
    logic        rst;
    logic        jump;
    logic [31:0] addr;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        load;
    logic [4:0]  regw;
    logic        div_start;
    logic        ready;
    logic        bus_hold;
  } stim_t;

  typedef struct {
    logic [5:0]  flags;
    logic [31:0] addr;
    logic [1:0]  st;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  logic        clk = 1'b0;
  stim_t       s;
  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] mcnt  = '0;
  logic [3:0]  mcnt4 = '0;

  logic        hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump_flag;
  logic [31:0] jump_addr;
  logic [1:0]  state;
  logic [31:0] stall_cnt;
  logic        hold_pc4, hold_if_id4, hold_id_ex4, flush_if_id4, flush_id_ex4, jump_flag4;
  logic [31:0] jump_addr4;
  logic [1:0]  state4;
  logic [3:0]  stall_cnt4;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst(s.rst),
    .ex_jump_flag_i(s.jump), .ex_jump_addr_i(s.addr),
    .id_reg1_addr_i(s.r1), .id_reg2_addr_i(s.r2),
    .ex_load_i(s.load), .ex_regw_addr_i(s.regw),
    .ex_div_start_i(s.div_start), .div_ready_i(s.ready), .bus_hold_i(s.bus_hold),
    .hold_pc_o(hold_pc), .hold_if_id_o(hold_if_id), .hold_id_ex_o(hold_id_ex),
    .flush_if_id_o(flush_if_id), .flush_id_ex_o(flush_id_ex),
    .jump_flag_o(jump_flag), .jump_addr_o(jump_addr),
    .state_o(state), .stall_cnt_o(stall_cnt)
  );

  pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(s.rst),
    .ex_jump_flag_i(s.jump), .ex_jump_addr_i(s.addr),
    .id_reg1_addr_i(s.r1), .id_reg2_addr_i(s.r2),
    .ex_load_i(s.load), .ex_regw_addr_i(s.regw),
    .ex_div_start_i(s.div_start), .div_ready_i(s.ready), .bus_hold_i(s.bus_hold),
    .hold_pc_o(hold_pc4), .hold_if_id_o(hold_if_id4), .hold_id_ex_o(hold_id_ex4),
    .flush_if_id_o(flush_if_id4), .flush_id_ex_o(flush_id_ex4),
    .jump_flag_o(jump_flag4), .jump_addr_o(jump_addr4),
    .state_o(state4), .stall_cnt_o(stall_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t r;
    r     = '0;
    r.rst = 1'b1;
    return r;
  endfunction

  // Queue the expectation for the current stimulus, compare mid-cycle, then advance.
  task automatic cyc(input logic [5:0] flags, input logic [31:0] addr, input logic [1:0] st);
    exp_t e;
    e.flags = flags; e.addr = addr; e.st = st; e.cnt = mcnt; e.cnt4 = mcnt4;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("flags", 32'({hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump_flag}),
            32'(e.flags));
      check("jump_addr", jump_addr, e.addr);
      check("state", 32'(state), 32'(e.st));
      check("stall_cnt", stall_cnt, e.cnt);
      check("stall_cnt4", 32'(stall_cnt4), 32'(e.cnt4));
    end
    @(posedge clk);
    #1;
    if (!s.rst) begin
      mcnt  = '0;
      mcnt4 = '0;
    end else if (flags[5]) begin
      if (mcnt != '1)    mcnt++;
      if (mcnt4 != 4'hf) mcnt4++;
    end
    s = idle();
  endtask

  task automatic do_reset();
    s.rst = 1'b0;
    cyc(NONE, 32'h0, RUN);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset with random inputs; the first edge only establishes a known state.
    s = idle();
    s.rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      s.rst       = 1'b0;
      s.jump      = 1'($urandom_range(0, 1));
      s.addr      = $urandom;
      s.r1        = 5'($urandom_range(0, 31));
      s.r2        = 5'($urandom_range(0, 31));
      s.load      = 1'($urandom_range(0, 1));
      s.regw      = 5'($urandom_range(0, 31));
      s.div_start = 1'($urandom_range(0, 1));
      s.ready     = 1'($urandom_range(0, 1));
      s.bus_hold  = 1'($urandom_range(0, 1));
      cyc(NONE, 32'h0, RUN);
    end
    cyc(NONE, 32'h0, RUN);

    // Redirect, then one more flush cycle, then back to RUN.
    s.jump = 1'b1; s.addr = 32'h100;
    cyc(JMP, 32'h100, RUN);
    cyc(FIF, 32'h0, FLS);
    cyc(NONE, 32'h0, RUN);

    // Jump inside FLUSH restarts the window with the newer target.
    s.jump = 1'b1; s.addr = 32'h180;
    cyc(JMP, 32'h180, RUN);
    s.jump = 1'b1; s.addr = 32'h400;
    cyc(JMP, 32'h400, FLS);
    cyc(FIF, 32'h0, FLS);
    cyc(NONE, 32'h0, RUN);

    // Load-use bubbles.
    do_reset();
    s.load = 1'b1; s.regw = 5'd5; s.r1 = 5'd3; s.r2 = 5'd5;
    cyc(LU, 32'h0, RUN);
    cyc(NONE, 32'h0, RUN);
    check("lu_stall_cnt", stall_cnt, 32'd1);
    s.load = 1'b1; s.regw = 5'd0; s.r1 = 5'd0; s.r2 = 5'd0;
    cyc(NONE, 32'h0, RUN);
    s.load = 1'b0; s.regw = 5'd7; s.r1 = 5'd7;
    cyc(NONE, 32'h0, RUN);
    s.load = 1'b1; s.regw = 5'd7; s.r1 = 5'd7; s.r2 = 5'd9;
    cyc(LU, 32'h0, RUN);
    cyc(NONE, 32'h0, RUN);

    // Divide: 33 held cycles, a jump mid-wait is ignored.
    do_reset();
    s.div_start = 1'b1;
    cyc(H3, 32'h0, RUN);
    for (int i = 1; i <= 32; i++) begin
      if (i == 10) begin
        s.jump = 1'b1; s.addr = 32'h200;
      end
      if (i == 20) s.bus_hold = 1'b1;
      cyc(H3, 32'h0, DIV);
    end
    s.ready = 1'b1;
    cyc(NONE, 32'h0, DIV);
    cyc(NONE, 32'h0, RUN);
    check("div_stall_cnt", stall_cnt, 32'd33);

    // Everything at once: redirect wins, pending halt is taken afterwards.
    do_reset();
    s.jump = 1'b1; s.addr = 32'h300; s.div_start = 1'b1; s.bus_hold = 1'b1;
    s.load = 1'b1; s.regw = 5'd4; s.r1 = 5'd4;
    cyc(JMP, 32'h300, RUN);
    s.bus_hold = 1'b1;
    cyc(FIF, 32'h0, FLS);
    s.bus_hold = 1'b1;
    cyc(H3, 32'h0, RUN);
    s.bus_hold = 1'b1;
    cyc(H3, 32'h0, HLT);
    cyc(NONE, 32'h0, HLT);
    cyc(NONE, 32'h0, RUN);

    // Saturation of the 4-bit counter, then reset while halted.
    do_reset();
    s.bus_hold = 1'b1;
    cyc(H3, 32'h0, RUN);
    for (int i = 1; i < 20; i++) begin
      s.bus_hold = 1'b1;
      cyc(H3, 32'h0, HLT);
    end
    s.bus_hold = 1'b1; s.rst = 1'b0;
    cyc(NONE, 32'h0, HLT);
    check("sat_cnt4_before_reset", 32'(stall_cnt4), 32'd0);
    check("state_after_reset", 32'(state), 32'(RUN));
    cyc(NONE, 32'h0, RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Saturation observed directly while the long halt is still in progress.
  initial begin
    wait (mcnt == 32'd20 && s.bus_hold && s.rst);
    @(negedge clk);
    check("sat_stall_cnt", stall_cnt, 32'd20);
    check("sat_stall_cnt4", 32'(stall_cnt4), 32'd15);
  end

endmodule
